// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter. It holds the
// receiver state encoding, the character width and the parity-select
// encoding, plus the parity helper used by both directions.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int   DATA_BITS = 7;

   // Parity select encoding (p_s input)
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // Parity bit that a well-formed frame carries for this character.
   function automatic logic expected_parity(input logic [DATA_BITS-1:0] data,
                                            input logic                 p_s);
      return (^data) ^ p_s;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
//   clk   : receiver clock
//   rst   : asynchronous active-high reset (all flops reset to idle-high)
//   rxd   : raw serial line, asynchronous to clk
//   s_rxd : synchronized line, two cycles behind rxd
//   fall  : high for one cycle when s_rxd goes from 1 to 0
// ---------------------------------------------------------------------------
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   output logic s_rxd,
   output logic fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= rxd;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign s_rxd = sync_reg;
   // A line held low never produces a second edge, which is what keeps a
   // break condition from retriggering the receiver.
   assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start, 7 data bits LSB first, parity, stop.
//   CLKS_PER_BIT : clocks per serial bit (1..1024)
//   clk, rst     : clock, asynchronous active-high reset
//   rxd          : serial line (idle high)
//   p_s          : parity select (0 even, 1 odd), captured at the start bit
//   rd           : consumer acknowledge, clears full and overrun
//   din_rx       : last good character
//   valid        : one-cycle pulse when din_rx is loaded
//   full         : din_rx holds an unread character
//   busy         : receiver is not idle
//   parity_err   : one-cycle pulse on parity mismatch
//   frame_err    : one-cycle pulse on a low stop bit
//   overrun      : sticky, good frame dropped because full was set
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   input  logic                 p_s,
   input  logic                 rd,
   output logic [DATA_BITS-1:0] din_rx,
   output logic                 valid,
   output logic                 full,
   output logic                 busy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int              CW         = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0]   LAST_CNT   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   SAMPLE_CNT = CW'((CLKS_PER_BIT - 1) / 2);
   // The cycle in which the falling edge is seen is position 0 of the start
   // bit, so the counter continues from position 1 (or wraps to 0 when a bit
   // is a single clock long).
   localparam logic [CW-1:0]   FIRST_CNT  = (CLKS_PER_BIT == 1) ? CW'(0) : CW'(1);
   localparam logic [2:0]      LAST_BIT   = 3'(DATA_BITS - 1);

   logic                 s_rxd;
   logic                 fall;

   uart_state_t          state_reg;
   logic [CW-1:0]        cnt_reg;
   logic [2:0]           bit_idx_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 ps_reg;
   logic                 par_bad_reg;
   logic                 stop_done_reg;

   logic [CW-1:0]        cnt_wrap;
   logic                 tick;
   logic                 frame_start;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .rxd   (rxd),
      .s_rxd (s_rxd),
      .fall  (fall)
   );

   assign cnt_wrap = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
   assign tick     = (cnt_reg == SAMPLE_CNT);
   // A new frame may also begin in the cycle after the stop sample, which
   // lets single-clock-per-bit frames run back to back.
   assign frame_start = fall && ((state_reg == IDLE) ||
                                 (state_reg == STOP && stop_done_reg));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         ps_reg        <= PAR_EVEN;
         par_bad_reg   <= 1'b0;
         stop_done_reg <= 1'b0;
         din_rx        <= '0;
         valid         <= 1'b0;
         full          <= 1'b0;
         busy          <= 1'b0;
         parity_err    <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;

         // Acknowledge; a load in the same cycle overrides this below.
         if (rd) begin
            full    <= 1'b0;
            overrun <= 1'b0;
         end

         if (state_reg == IDLE) cnt_reg <= '0;
         else                   cnt_reg <= cnt_wrap;

         if (frame_start) begin
            cnt_reg       <= FIRST_CNT;
            bit_idx_reg   <= '0;
            par_bad_reg   <= 1'b0;
            stop_done_reg <= 1'b0;
            busy          <= 1'b1;
            if (SAMPLE_CNT == '0) begin
               // The edge cycle is already the start-bit sample point.
               state_reg <= DATA;
               ps_reg    <= p_s;
            end else begin
               state_reg <= START;
            end
         end else begin
            case (state_reg)
               IDLE: ;

               START: if (tick) begin
                  if (!s_rxd) begin
                     state_reg <= DATA;
                     ps_reg    <= p_s;
                  end else begin
                     state_reg <= IDLE;   // false start, silently dropped
                     busy      <= 1'b0;
                  end
               end

               DATA: if (tick) begin
                  shift_reg <= {s_rxd, shift_reg[DATA_BITS-1:1]};
                  if (bit_idx_reg == LAST_BIT) state_reg <= PARITY;
                  else                         bit_idx_reg <= bit_idx_reg + 1'b1;
               end

               PARITY: if (tick) begin
                  par_bad_reg <= (expected_parity(shift_reg, ps_reg) != s_rxd);
                  state_reg   <= STOP;
               end

               STOP: begin
                  if (stop_done_reg) begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end else if (tick) begin
                     stop_done_reg <= 1'b1;
                     if (!s_rxd) begin
                        frame_err  <= 1'b1;
                        parity_err <= par_bad_reg;
                     end else if (par_bad_reg) begin
                        parity_err <= 1'b1;
                     end else if (full && !rd) begin
                        overrun <= 1'b1;   // keep the unread character
                     end else begin
                        din_rx <= shift_reg;
                        valid  <= 1'b1;
                        full   <= 1'b1;
                     end
                  end
               end

               default: begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx at 16 and 1 clocks per bit. Stimulus pushes
// the expected output event (valid / parity_err / frame_err) into a queue;
// a monitor per instance pops and compares whenever an event appears.
// ---------------------------------------------------------------------------
module tb_uart_rx;
   import uart_pkg::*;

   typedef struct packed {
      logic       v;
      logic       pe;
      logic       fe;
      logic [6:0] d;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd16, ps16, rd16;
   logic       rxd1,  ps1,  rd1;
   logic [6:0] din16, din1;
   logic       valid16, full16, busy16, perr16, ferr16, ovr16;
   logic       valid1,  full1,  busy1,  perr1,  ferr1,  ovr1;

   int errors = 0;
   int checks = 0;

   ev_t q16[$];
   ev_t q1[$];
   ev_t got16, exp16, got1, exp1;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .clk(clk), .rst(rst), .rxd(rxd16), .p_s(ps16), .rd(rd16),
      .din_rx(din16), .valid(valid16), .full(full16), .busy(busy16),
      .parity_err(perr16), .frame_err(ferr16), .overrun(ovr16)
   );

   uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .rxd(rxd1), .p_s(ps1), .rd(rd1),
      .din_rx(din1), .valid(valid1), .full(full1), .busy(busy1),
      .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1)
   );

   function automatic ev_t mk_ev(input logic v, input logic pe, input logic fe,
                                 input logic [6:0] d);
      return {v, pe, fe, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("check %s ok (%0h)", name, act);
      end
   endtask

   // Monitors: compare every output event against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && (valid16 || perr16 || ferr16)) begin
         got16 = mk_ev(valid16, perr16, ferr16, valid16 ? din16 : 7'd0);
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL mon16 unexpected event: got %b required none", got16);
         end else begin
            exp16 = q16.pop_front();
            if (got16 !== exp16) begin
               errors++;
               $display("FAIL mon16 event: got %b required %b", got16, exp16);
            end else begin
               $display("mon16 event ok %b", got16);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && (valid1 || perr1 || ferr1)) begin
         got1 = mk_ev(valid1, perr1, ferr1, valid1 ? din1 : 7'd0);
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL mon1 unexpected event: got %b required none", got1);
         end else begin
            exp1 = q1.pop_front();
            if (got1 !== exp1) begin
               errors++;
               $display("FAIL mon1 event: got %b required %b", got1, exp1);
            end else begin
               $display("mon1 event ok %b", got1);
            end
         end
      end
   end

   // Serial frame at 16 clocks per bit; the line is left at the stop value.
   task automatic send16(input logic [6:0] d, input logic par, input logic stop);
      logic [9:0] f;
      f = {stop, par, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd16 = f[i];
         repeat (16) @(negedge clk);
      end
   endtask

   // One-bit-per-clock transmitter model.
   task automatic send1(input logic [6:0] d, input logic par, input logic stop);
      logic [9:0] f;
      f = {stop, par, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd1 = f[i];
         @(negedge clk);
      end
   endtask

   task automatic wait_ev16(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (valid16 || perr16 || ferr16) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_rd16();
      rd16 = 1'b1;
      @(negedge clk);
      rd16 = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int cnt;

      rst = 1'b1;
      rxd16 = 1'b1; ps16 = PAR_EVEN; rd16 = 1'b0;
      rxd1  = 1'b1; ps1  = PAR_EVEN; rd1  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset16_outputs", {din16, valid16, full16, busy16, perr16, ferr16, ovr16}, 0);
      chk("reset1_outputs",  {din1,  valid1,  full1,  busy1,  perr1,  ferr1,  ovr1},  0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Good frame, even parity: 0011011 has four ones -> parity 0.
      q16.push_back(mk_ev(1'b1, 1'b0, 1'b0, 7'b0011011));
      fork
         send16(7'b0011011, 1'b0, 1'b1);
         begin
            wait_ev16(ok);
            chk("good_event_seen", ok, 1);
            chk("good_din", din16, 7'b0011011);
            chk("good_full", full16, 1);
            chk("good_busy_at_valid", busy16, 1);
            @(negedge clk);
            chk("good_busy_low_after", busy16, 0);
         end
      join
      pulse_rd16();
      chk("rd_clears_full", full16, 0);

      // Odd parity selected but parity bit 0 -> parity error, nothing loaded.
      ps16 = PAR_ODD;
      q16.push_back(mk_ev(1'b0, 1'b1, 1'b0, 7'd0));
      fork
         send16(7'b0011011, 1'b0, 1'b1);
         begin
            wait_ev16(ok);
            chk("perr_event_seen", ok, 1);
            chk("perr_full_stays_0", full16, 0);
         end
      join
      ps16 = PAR_EVEN;
      repeat (10) @(negedge clk);

      // Quarter-bit glitch: false start, busy for at most 8 cycles.
      rxd16 = 1'b0;
      repeat (4) @(negedge clk);
      rxd16 = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy16) cnt++;
      end
      chk("glitch_busy_1_to_8", (cnt >= 1 && cnt <= 8), 1);
      chk("glitch_idle_after", busy16, 0);

      // Low stop bit, then break for three frame times.
      q16.push_back(mk_ev(1'b0, 1'b0, 1'b1, 7'd0));
      fork
         send16(7'b1010101, 1'b0, 1'b0);
         begin
            wait_ev16(ok);
            chk("ferr_event_seen", ok, 1);
         end
      join
      cnt = 0;
      for (int i = 0; i < 480; i++) begin
         @(negedge clk);
         if (busy16) cnt++;
      end
      chk("break_no_restart", cnt, 0);
      rxd16 = 1'b1;
      repeat (32) @(negedge clk);
      chk("break_release_idle", busy16, 0);

      // Two good frames without rd: first kept, second dropped with overrun.
      q16.push_back(mk_ev(1'b1, 1'b0, 1'b0, 7'b1010101));
      send16(7'b1010101, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      send16(7'b0000001, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("ovr_full", full16, 1);
      chk("ovr_set", ovr16, 1);
      chk("ovr_din_kept", din16, 7'b1010101);
      pulse_rd16();
      chk("ovr_rd_full", full16, 0);
      chk("ovr_rd_overrun", ovr16, 0);

      // Good frame with odd parity: 0011011 odd -> parity bit 1.
      ps16 = PAR_ODD;
      q16.push_back(mk_ev(1'b1, 1'b0, 1'b0, 7'b0011011));
      fork
         send16(7'b0011011, 1'b1, 1'b1);
         begin
            wait_ev16(ok);
            chk("odd_event_seen", ok, 1);
            chk("odd_din", din16, 7'b0011011);
         end
      join
      pulse_rd16();

      // One clock per bit, two frames back to back, rd held high.
      rd1 = 1'b1;
      q1.push_back(mk_ev(1'b1, 1'b0, 1'b0, 7'b0011011));
      q1.push_back(mk_ev(1'b1, 1'b0, 1'b0, 7'b1111111));
      send1(7'b0011011, 1'b0, 1'b1);
      send1(7'b1111111, 1'b1, 1'b1);
      rxd1 = 1'b1;
      repeat (20) @(negedge clk);
      chk("b2b_both_received", q1.size(), 0);
      chk("b2b_last_din", din1, 7'b1111111);
      chk("b2b_no_overrun", ovr1, 0);
      rd1 = 1'b0;

      // Reset in the middle of a frame.
      rxd1 = 1'b0; @(negedge clk);
      rxd1 = 1'b1; @(negedge clk);
      rxd1 = 1'b0; @(negedge clk);
      rst = 1'b1;
      rxd1 = 1'b1;
      #2;
      chk("midrst1_outputs", {din1, valid1, full1, busy1, perr1, ferr1, ovr1}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst1_idle", busy1, 0);
      q1.push_back(mk_ev(1'b1, 1'b0, 1'b0, 7'b0011011));
      send1(7'b0011011, 1'b0, 1'b1);
      rxd1 = 1'b1;
      repeat (20) @(negedge clk);
      chk("after_rst_received", q1.size(), 0);
      chk("after_rst_din", din1, 7'b0011011);
      chk("after_rst_full", full1, 1);

      repeat (20) @(negedge clk);
      chk("sb16_drained", q16.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
